// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage access unit: access sizes, FSM states,
// timeout counter width and the natural-alignment check.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int TO_CNT_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE,
      S_ERR
   } state_t;

   // Size 11 behaves like a word, so anything that is not byte or half needs lane 0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      if (size == SZ_BYTE) return 1'b0;
      if (size == SZ_HALF) return lo[0];
      return lo != 2'b00;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;

   modport master (
      output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
      input  dm_rdata, dm_ack
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
      output dm_rdata, dm_ack
   );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store data replication and byte enables on the way out,
// load lane selection and sign/zero extension on the way back.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_res
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Sub-word accesses snap to their natural lane, so misaligned low bits are simply dropped.
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      load_res  = rdata;
      byte_val  = rdata[{addr_lo, 3'b000} +: 8];
      half_val  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            load_res  = is_unsigned ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
         end
         SZ_HALF: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            load_res  = is_unsigned ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            load_res  = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: req/ack handshake with timeout and pipeline stall.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating them.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [1:0]  ex_size,
   input  logic        ex_unsigned,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   output logic        stall,
   output logic        mem_valid,
   output logic [31:0] mem_data_res,
   output logic        bus_err,
   output logic        misalign_err,
   mem_access_unit_if.master dm
);

   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

   state_t              state;
   state_t              next_state;
   logic                accept;
   logic                cap_we;
   logic [1:0]          cap_size;
   logic                cap_uns;
   logic [31:0]         cap_addr;
   logic [31:0]         cap_wdata;
   logic [TO_CNT_W-1:0] tcount;
   logic [31:0]         res_q;
   logic                req_q;
   logic [3:0]          lane_be;
   logic [31:0]         lane_wdata;
   logic [31:0]         lane_load;

   mem_lane_align u_align (
      .size        (cap_size),
      .addr_lo     (cap_addr[1:0]),
      .is_unsigned (cap_uns),
      .wdata       (cap_wdata),
      .rdata       (dm.dm_rdata),
      .be          (lane_be),
      .wdata_rep   (lane_wdata),
      .load_res    (lane_load)
   );

   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   // An ack landing on the final allowed cycle still completes the access.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      stall      = 1'b0;
      case (state)
         S_IDLE: begin
            if (ex_valid && (ex_mem_read || ex_mem_write)) begin
               accept     = 1'b1;
               stall      = 1'b1;
               next_state = S_REQ;
`ifdef MISALIGN_TRAP_EN
               if (is_misaligned(ex_size, ex_addr[1:0])) next_state = S_ERR;
`endif
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (dm.dm_ack)              next_state = S_DONE;
            else if (tcount == TO_LAST) next_state = S_ERR;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cap_we    <= 1'b0;
         cap_size  <= SZ_BYTE;
         cap_uns   <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         tcount    <= '0;
         res_q     <= '0;
         req_q     <= 1'b0;
      end else begin
         req_q <= (next_state == S_REQ);
         if (accept) begin
            cap_we    <= ex_mem_write;
            cap_size  <= ex_size;
            cap_uns   <= ex_unsigned;
            cap_addr  <= ex_addr;
            cap_wdata <= ex_wdata;
            tcount    <= '0;
         end else if (state == S_REQ && !dm.dm_ack) begin
            tcount <= tcount + 1'b1;
         end
         if (state == S_REQ && dm.dm_ack) res_q <= cap_we ? '0 : lane_load;
         if (next_state == S_ERR)         res_q <= '0;
      end
   end

   assign dm.dm_req    = req_q;
   assign dm.dm_we     = req_q & cap_we;
   assign dm.dm_addr   = {cap_addr[31:2], 2'b00};
   assign dm.dm_be     = req_q ? lane_be : 4'b0000;
   assign dm.dm_wdata  = lane_wdata;
   assign mem_valid    = (state == S_DONE);
   assign mem_data_res = res_q;

`ifdef MISALIGN_TRAP_EN
   logic err_misalign;

   // Remembers which error sent us to ERR so the right pulse is raised there.
   always_ff @(posedge clock) begin
      if (!reset)      err_misalign <= 1'b0;
      else if (accept) err_misalign <= (next_state == S_ERR);
   end

   assign bus_err      = (state == S_ERR) & ~err_misalign;
   assign misalign_err = (state == S_ERR) &  err_misalign;
`else
   assign bus_err      = (state == S_ERR);
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against a lane/extension model
// computed from byte offsets and masks.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_mem_read = 1'b0;
   logic        ex_mem_write = 1'b0;
   logic [1:0]  ex_size = 2'b00;
   logic        ex_unsigned = 1'b0;
   logic [31:0] ex_addr = '0;
   logic [31:0] ex_wdata = '0;
   logic        stall;
   logic        mem_valid;
   logic [31:0] mem_data_res;
   logic        bus_err;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   mem_access_unit_if dm_bus ();

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clock        (clock),
      .reset        (reset),
      .ex_valid     (ex_valid),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_size      (ex_size),
      .ex_unsigned  (ex_unsigned),
      .ex_addr      (ex_addr),
      .ex_wdata     (ex_wdata),
      .stall        (stall),
      .mem_valid    (mem_valid),
      .mem_data_res (mem_data_res),
      .bus_err      (bus_err),
      .misalign_err (misalign_err),
      .dm           (dm_bus)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      if (sz == 2'b00) return 1;
      if (sz == 2'b01) return 2;
      return 4;
   endfunction

   function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
      int lo;
      lo = int'(a[1:0]);
      if (sz == 2'b00) return lo;
      if (sz == 2'b01) return (lo / 2) * 2;
      return 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
      logic [31:0] t;
      t = ((32'd1 << nbytes(sz)) - 32'd1) << lane_off(sz, a);
      return t[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [63:0] mask;
      logic [63:0] r;
      int nb;
      nb   = nbytes(sz);
      mask = (64'd1 << (8 * nb)) - 64'd1;
      r    = '0;
      for (int k = 0; k < 4 / nb; k++) r = r | (({32'b0, wd} & mask) << (8 * nb * k));
      return r[31:0];
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                              input logic uns, input logic [31:0] rd);
      logic [63:0] mask;
      logic [63:0] v;
      int nb;
      nb   = nbytes(sz);
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = ({32'b0, rd} >> (8 * lane_off(sz, a))) & mask;
      if (!uns && v[8 * nb - 1]) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic bench_misaligned(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b00) return 1'b0;
      if (sz == 2'b01) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   // One instruction: accept cycle, REQ cycles with an ack after d waits, then completion.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdat, input int d);
      logic exp_mis;
      logic acked;
      exp_mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      exp_mis = bench_misaligned(sz, addr);
`endif
      ex_valid     = 1'b1;
      ex_mem_read  = rd;
      ex_mem_write = wr;
      ex_size      = sz;
      ex_unsigned  = uns;
      ex_addr      = addr;
      ex_wdata     = wd;
      #1;
      checkBit("stall_accept", stall, 1'b1);
      checkBit("req_accept", dm_bus.dm_req, 1'b0);
      @(posedge clock); #1;
      if (exp_mis) begin
         checkBit("misalign_err", misalign_err, 1'b1);
         checkBit("misalign_noreq", dm_bus.dm_req, 1'b0);
         checkBit("misalign_stall", stall, 1'b0);
         checkBit("misalign_valid", mem_valid, 1'b0);
         checkBit("misalign_buserr", bus_err, 1'b0);
         checkOutput("misalign_res", mem_data_res, 32'h0);
      end else begin
         acked = 1'b0;
         for (int k = 0; k < TO && !acked; k++) begin
            dm_bus.dm_ack   = (k == d);
            dm_bus.dm_rdata = (k == d) ? rdat : $urandom;
            #1;
            checkBit("req_high", dm_bus.dm_req, 1'b1);
            checkBit("req_we", dm_bus.dm_we, wr);
            checkBit("req_stall", stall, 1'b1);
            checkOutput("req_addr", dm_bus.dm_addr, {addr[31:2], 2'b00});
            checkOutput("req_be", 32'(dm_bus.dm_be), 32'(model_be(sz, addr)));
            if (wr) checkOutput("req_wdata", dm_bus.dm_wdata, model_wdata(sz, wd));
            @(posedge clock); #1;
            dm_bus.dm_ack = 1'b0;
            if (k == d) acked = 1'b1;
         end
         if (acked) begin
            checkBit("done_valid", mem_valid, 1'b1);
            checkOutput("done_res", mem_data_res, wr ? 32'h0 : model_load(sz, addr, uns, rdat));
            checkBit("done_buserr", bus_err, 1'b0);
         end else begin
            checkBit("to_buserr", bus_err, 1'b1);
            checkBit("to_valid", mem_valid, 1'b0);
            checkOutput("to_res", mem_data_res, 32'h0);
         end
         checkBit("end_stall", stall, 1'b0);
         checkBit("end_req", dm_bus.dm_req, 1'b0);
      end
      ex_valid     = 1'b0;
      ex_mem_read  = 1'b0;
      ex_mem_write = 1'b0;
      @(posedge clock); #1;
      checkBit("idle_valid", mem_valid, 1'b0);
      checkBit("idle_buserr", bus_err, 1'b0);
      checkBit("idle_misalign", misalign_err, 1'b0);
      checkBit("idle_req", dm_bus.dm_req, 1'b0);
   endtask

   initial begin
      logic       rd;
      logic       wr;
      logic [1:0] sz;

      dm_bus.dm_ack   = 1'b0;
      dm_bus.dm_rdata = '0;
      @(posedge clock); @(posedge clock); #1;
      checkBit("rst_req", dm_bus.dm_req, 1'b0);
      checkBit("rst_we", dm_bus.dm_we, 1'b0);
      checkBit("rst_valid", mem_valid, 1'b0);
      checkBit("rst_buserr", bus_err, 1'b0);
      checkBit("rst_misalign", misalign_err, 1'b0);
      checkOutput("rst_addr", dm_bus.dm_addr, 32'h0);
      checkOutput("rst_be", 32'(dm_bus.dm_be), 32'h0);
      checkOutput("rst_wdata", dm_bus.dm_wdata, 32'h0);
      checkOutput("rst_res", mem_data_res, 32'h0);
      reset = 1'b1;
      @(posedge clock); #1;

      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
      applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0);
      applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, 32'hC3A5_9E71, 3);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 99);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h1234_5678, 0);
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h55, 1);
      applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0030, 32'h0, 32'h8765_4321, 2);

      // Non-memory instruction with a stray ack must not start anything.
      ex_valid      = 1'b1;
      dm_bus.dm_ack = 1'b1;
      #1;
      checkBit("nonmem_stall", stall, 1'b0);
      @(posedge clock); #1;
      checkBit("nonmem_req", dm_bus.dm_req, 1'b0);
      checkBit("nonmem_valid", mem_valid, 1'b0);
      ex_valid      = 1'b0;
      dm_bus.dm_ack = 1'b0;

      for (int n = 0; n < 40; n++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if (!rd && !wr) rd = 1'b1;
         sz = 2'($urandom_range(0, 3));
         applyStimulus(rd, wr, sz, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                       $urandom_range(0, 5));
      end

      // Reset during REQ with an ack arriving on the same edge.
      ex_valid     = 1'b1;
      ex_mem_read  = 1'b1;
      ex_size      = 2'b10;
      ex_addr      = 32'h0000_0020;
      @(posedge clock); #1;
      checkBit("mid_req", dm_bus.dm_req, 1'b1);
      reset           = 1'b0;
      ex_valid        = 1'b0;
      ex_mem_read     = 1'b0;
      dm_bus.dm_ack   = 1'b1;
      dm_bus.dm_rdata = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      checkBit("mid_rst_req", dm_bus.dm_req, 1'b0);
      checkBit("mid_rst_valid", mem_valid, 1'b0);
      checkBit("mid_rst_stall", stall, 1'b0);
      reset         = 1'b1;
      dm_bus.dm_ack = 1'b0;
      @(posedge clock); #1;
      checkBit("post_rst_valid", mem_valid, 1'b0);
      checkBit("post_rst_buserr", bus_err, 1'b0);
      checkOutput("post_rst_addr", dm_bus.dm_addr, 32'h0);
      checkOutput("post_rst_be", 32'(dm_bus.dm_be), 32'h0);
      checkOutput("post_rst_wdata", dm_bus.dm_wdata, 32'h0);
      checkOutput("post_rst_res", mem_data_res, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access controller between the EX/MEM pipeline register and the MEM/WB pipeline register. Takes one load/store per instruction, aligns store data and byte enables, runs a req/ack handshake to data memory, and stalls the pipeline until the access completes. Extracts and sign- or zero-extends load data into `mem_data_res` for MEM/WB. Detects bus timeouts and, optionally, misaligned accesses.

## Interface
- `TIMEOUT_CYCLES`, 255: REQ cycles without `dm_ack` before a bus error; range 1..255.
- `clock` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-low.
- `ex_valid` in 1: EX/MEM holds a valid instruction.
- `ex_mem_read` in 1: load.
- `ex_mem_write` in 1: store.
- `ex_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `ex_unsigned` in 1: zero-extend loads (LBU/LHU).
- `ex_addr` in 32: byte address.
- `ex_wdata` in 32: store data, right-justified.
- `stall` out 1: hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB must not capture.
- `mem_valid` out 1: one-cycle pulse, access finished; `mem_data_res` valid.
- `mem_data_res` out 32: extended load data; 0 for stores and errors.
- `bus_err` out 1: one-cycle pulse, timeout.
- `misalign_err` out 1: one-cycle pulse, misaligned access (macro only).
- `dm_req` out 1: memory request, registered.
- `dm_we` out 1: write.
- `dm_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `dm_be` out 4: byte enables, bit n = bits 8n+7:8n.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_rdata` in 32: read data, valid with `dm_ack`.
- `dm_ack` in 1: completes the request in the same cycle.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE: if `ex_valid & (ex_mem_read | ex_mem_write)`, capture the op, size, unsigned flag, address, and data. Go to REQ; with `MISALIGN_TRAP_EN` and a misaligned address, go to ERR instead. Otherwise stay in IDLE.
- REQ: `dm_req`=1 with the captured address, enables, and data. On `dm_ack`, latch extracted load data and go to DONE. If the timeout counter reaches `TIMEOUT_CYCLES`, go to ERR.
- DONE: `mem_valid`=1. Ignore inputs, including the stale `ex_valid`. Next state is IDLE.
- ERR: assert `bus_err` or `misalign_err`; `mem_data_res`=0, `mem_valid`=0. Next state is IDLE.
- Read and write both set: perform the store; `mem_data_res`=0.
- Stores:
  - Byte: `wdata[7:0]` replicated ×4; `dm_be = 1<<addr[1:0]`.
  - Half: `{wdata[15:0],wdata[15:0]}`; `dm_be` 0011 (addr[1]=0) or 1100.
  - Word: `dm_be` 1111.
- Loads: select the little-endian lane from `addr[1:0]`, then sign-extend, or zero-extend if `ex_unsigned`.
- Timeout counter: 8 bits. Cleared on entry to REQ; increments each REQ cycle without ack.
- `dm_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `dm_req`, `dm_we`, `mem_valid`, `bus_err`, `misalign_err` = 0; `dm_addr`, `dm_be`, `dm_wdata`, `mem_data_res`, counter = 0.
- `stall` is combinational:
  - high in IDLE when accepting a memory op;
  - high throughout REQ;
  - low in DONE and ERR.
- Latency with ack in the first REQ cycle:
  - accept at cycle t;
  - `dm_req` high at t+1;
  - `mem_valid` at t+2, when MEM/WB captures and the pipeline advances.
- Each wait cycle adds one cycle of latency.
- Non-memory instructions: `stall`=0, zero latency, no request.
- Ack on the same cycle the counter hits the limit: the ack wins.
- Reset asserted mid-access: IDLE on the next edge, `dm_req` drops, and the pending ack is ignored.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - half with addr[0]=1, or word with addr[1:0]≠0, issues no request;
  - ERR is entered at t+1 with `misalign_err`=1.
- Not defined:
  - `misalign_err` tied to 0;
  - low address bits are truncated to natural alignment (half uses addr[1], word uses lane 0) and the access proceeds.

## Structure
- Package `mem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum;
  - timeout counter width.
- Sub-module `mem_lane_align`: combinational store replication and byte-enable generation, plus load lane select and extension.

## Test plan
- LB from 0x103, rdata 0x80FF_1234, ack in first REQ cycle → `mem_valid` at t+2, `mem_data_res`=0xFFFF_FF80; `stall` high for t and t+1.
- SH data 0xABCD to 0x202 → `dm_addr`=0x200, `dm_be`=1100, `dm_wdata`=0xABCD_ABCD, `dm_we`=1.
- LHU from 0x10, ack after 3 wait cycles → `mem_data_res`=0x0000_xxxx from lane 0; `mem_valid` at t+5.
- No ack, `TIMEOUT_CYCLES`=4 → `bus_err` pulse after 4 REQ cycles; `dm_req` drops; `stall` releases.
- LW at 0x6 → with the macro: `misalign_err` at t+1 and no `dm_req`; without it: access to 0x4 with `dm_be`=1111.
- Reset pulled low during REQ, then ack arrives → IDLE, all outputs 0, no `mem_valid`.
